// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with a memory wait-state watchdog.
// Optional build macro ILLEGAL_TRAP_EN: ILLEGAL becomes a terminal trap state and the illegal_op port is added.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_tipo_r,
  output logic [3:0] alu_nao_r,
  output logic [1:0] pc_source,
  output logic       mem_err,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic       r_err;
  logic       w_mem_st;
  logic       w_timeout;
  logic       w_hold;
  logic       w_unused;

  // Branch resolution happens in the datapath; zero is only carried through the interface.
  assign w_unused  = zero;
  assign w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_mem_st && !mem_ready && (r_cnt == 8'(MEM_TIMEOUT - 1));
  assign w_hold    = w_mem_st && !mem_ready && !w_timeout;
  assign mem_err   = r_err;
  assign state_o   = r_state;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Wait-state counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_hold ? r_cnt + 8'd1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Next-state and Moore output decode; everything idles while reset is held.
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_tipo_r    = 1'b0;
    alu_nao_r     = ALU_ADD;
    pc_source     = 2'd0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = mem_ready ? 2'd1 : 2'd0;
          w_next    = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (OPCode)
            OP_R:                                             w_next = S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_SLTIU, OP_LUI:                        w_next = S_EXEC_I;
            OP_LW, OP_SW:                                     w_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                                   w_next = S_BRANCH;
            OP_J, OP_JAL:                                     w_next = S_JUMP;
            default:                                          w_next = S_ILLEGAL;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_tipo_r = 1'b1;
          w_next     = S_WB_R;
        end
        S_WB_R: begin
          reg_dst   = 2'd1;
          reg_write = 1'b1;
          w_next    = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          case (OPCode)
            OP_ANDI:  alu_nao_r = ALU_AND;
            OP_ORI:   alu_nao_r = ALU_OR;
            OP_XORI:  alu_nao_r = ALU_XOR;
            OP_SLTI:  alu_nao_r = ALU_SLT;
            OP_SLTIU: alu_nao_r = ALU_SLTU;
            OP_LUI:   alu_nao_r = ALU_LUI;
            default:  alu_nao_r = ALU_ADD;
          endcase
          w_next = S_WB_I;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          w_next    = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_next    = (OPCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          w_next   = mem_ready ? S_WB_MEM : S_MEM_RD;
        end
        S_WB_MEM: begin
          mem_to_reg = 2'd1;
          reg_write  = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          w_next    = mem_ready ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_nao_r     = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          branch_ne     = (OPCode == OP_BNE);
          w_next        = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          reg_write  = (OPCode == OP_JAL);
          reg_dst    = (OPCode == OP_JAL) ? 2'd2 : 2'd0;
          mem_to_reg = (OPCode == OP_JAL) ? 2'd2 : 2'd0;
          w_next     = S_FETCH;
        end
        S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
          illegal_op = 1'b1;
          w_next     = S_ILLEGAL;
`else
          w_next     = S_FETCH;
`endif
        end
        default: w_next = S_FETCH;
      endcase
      if (w_timeout) w_next = S_FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] OPCode = 6'd0;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_write, alu_src_a, alu_tipo_r, mem_err;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [3:0] alu_nao_r, state_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] seq;
  int          rw_cnt, mr_lo, mw_cnt;
  logic [3:0]  rw_st, alu_ex;
  logic [1:0]  m2r, dec_b, br;
  logic [7:0]  jmp;
  logic [5:0]  fch;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_tipo_r(alu_tipo_r), .alu_nao_r(alu_nao_r), .pc_source(pc_source), .mem_err(mem_err),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting at posedge+2 of a FETCH cycle, returns at posedge+2 of the next FETCH.
  task automatic run(input string tag, input logic [5:0] op, input int wt, input int exp_len);
    int n, w;
    n = 0; w = 0; seq = '0; rw_cnt = 0; mr_lo = 0; mw_cnt = 0;
    rw_st = 4'hF; alu_ex = 4'hF; m2r = 2'd0; dec_b = 2'd0; br = 2'd0; jmp = 8'd0; fch = 6'd0;
    OPCode = op;
    do begin
      if (state_o == 4'd0) mem_ready = 1'b1;
      else if (state_o == 4'd7 || state_o == 4'd9) mem_ready = (w >= wt);
      else mem_ready = 1'b0;
      if ((state_o == 4'd7 || state_o == 4'd9) && !mem_ready) w++;
      #1;
      n++;
      seq = {seq[59:0], state_o};
      if (reg_write) begin rw_cnt++; rw_st = state_o; end
      if (state_o == 4'd0)  fch = {ir_write, pc_write, alu_src_b, pc_source};
      if (state_o == 4'd1)  dec_b = alu_src_b;
      if (state_o == 4'd4)  alu_ex = alu_nao_r;
      if (state_o == 4'd8)  m2r = mem_to_reg;
      if (state_o == 4'd10) br = {pc_write_cond, branch_ne};
      if (state_o == 4'd11) jmp = {pc_write, pc_source, reg_write, reg_dst, mem_to_reg};
      if (state_o == 4'd7 && !mem_read) mr_lo++;
      if (mem_write) mw_cnt++;
      @(posedge clk); #2;
    end while (state_o != 4'd0 && n < 64);
    chk({tag, "_len"}, 64'(n), 64'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] iop  [6] = '{6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b001111};
    logic [3:0] ialu [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b0111, 4'b1100};
    int cnt;
    #3;
    chk("rst_state", state_o, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_alu", alu_nao_r, 4'b0010);
    chk("rst_err", mem_err, 0);
    chk("rst_sel", {pc_write, ir_write, alu_src_b, pc_source}, 0);
    @(posedge clk); #2; rst_n = 1'b1;

    run("addi", ADDI, 0, 4);
    chk("addi_seq", seq, 64'h0145);
    chk("addi_alu", alu_ex, 4'b0010);
    chk("addi_rw_cnt", rw_cnt, 1);
    chk("addi_rw_st", rw_st, 4'd5);
    chk("addi_fetch", fch, 6'b110100);
    chk("addi_dec_b", dec_b, 2'd3);
    run("add", 6'b000000, 0, 4);
    chk("add_seq", seq, 64'h0123);
    chk("add_rw_st", rw_st, 4'd3);
    run("lw", LW, 0, 5);
    chk("lw_seq", seq, 64'h01678);
    chk("lw_m2r", m2r, 2'd1);
    chk("lw_rw_st", rw_st, 4'd8);
    run("sw", SW, 0, 4);
    chk("sw_seq", seq, 64'h0169);
    chk("sw_rw", rw_cnt, 0);
    chk("sw_mw", mw_cnt, 1);
    zero = 1'b1;
    run("beq", 6'b000100, 0, 3);
    chk("beq_seq", seq, 64'h01A);
    chk("beq_br", br, 2'b10);
    zero = 1'b0;
    run("bne", 6'b000101, 0, 3);
    chk("bne_br", br, 2'b11);
    run("j", 6'b000010, 0, 3);
    chk("j_seq", seq, 64'h01B);
    chk("j_sig", jmp, 8'hC0);
    chk("j_rw", rw_cnt, 0);
    run("jal", 6'b000011, 0, 3);
    chk("jal_sig", jmp, 8'hDA);
    for (int i = 0; i < 6; i++) begin
      run("itype", iop[i], 0, 4);
      chk("itype_alu", alu_ex, ialu[i]);
    end

    run("lw_wait", LW, 3, 8);
    chk("lw_wait_seq", seq, 64'h01677778);
    chk("lw_wait_mr", mr_lo, 0);
    chk("lw_wait_err", mem_err, 0);

    run("sw_to", SW, 1000, 18);
    chk("sw_to_mw", mw_cnt, 15);
    chk("sw_to_rw", rw_cnt, 0);
    chk("sw_to_err", mem_err, 1);
    chk("sw_to_state", state_o, 0);
    repeat (25) run("idle", ADDI, 0, 4);
    chk("err_sticky", mem_err, 1);

    OPCode = SW; mem_ready = 1'b1;
    @(posedge clk); #2; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_pre_state", state_o, 4'd9);
    chk("rst_pre_mw", mem_write, 1);
    rst_n = 1'b0; #1;
    chk("rst_mw_drop", mem_write, 0);
    chk("rst_mr_low", mem_read, 0);
    chk("rst_async_state", state_o, 0);
    chk("rst_async_err", mem_err, 0);
    @(posedge clk); #2; rst_n = 1'b1; #1;
    chk("post_rst_state", state_o, 0);
    chk("post_rst_mr", mem_read, 1);
    chk("post_rst_err", mem_err, 0);
    @(posedge clk); #2;

`ifdef ILLEGAL_TRAP_EN
    OPCode = 6'b111111; mem_ready = 1'b1;
    @(posedge clk); #2; mem_ready = 1'b0;
    @(posedge clk); #2;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      mem_ready = i[0]; #1;
      if (state_o == 4'd12 && illegal_op && !mem_read && !mem_write && !reg_write && !pc_write) cnt++;
      @(posedge clk); #2;
    end
    chk("trap_hold", cnt, 50);
`else
    run("ill", 6'b111111, 0, 3);
    chk("ill_seq", seq, 64'h01C);
    #1;
    chk("ill_fetch_state", state_o, 0);
    chk("ill_fetch_mr", mem_read, 1);
    cnt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
